// File: rtl/axis_source.sv
// AXI-Stream master front end: local valid/ready writes into a small FWFT FIFO drained as m_axis_*.
// Optional packet framing (m_axis_tlast plus a beat counter) is enabled by defining AXIS_SOURCE_TLAST_EN.
module axis_source #(
  parameter int AXIS_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PKT_LEN    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid,
  input  logic [AXIS_WIDTH-1:0]   data_in,
  output logic                    ready,
  output logic                    m_axis_tvalid,
  output logic [AXIS_WIDTH-1:0]   m_axis_tdata,
  input  logic                    m_axis_tready,
`ifdef AXIS_SOURCE_TLAST_EN
  output logic                    m_axis_tlast,
`endif
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PKT_LEN < 1) begin : g_bad_params
      $error("axis_source: DEPTH must be a power of two >= 2 and PKT_LEN >= 1");
    end
  endgenerate

  logic [AXIS_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_en;
  logic                  rd_en;

  // Flow control depends only on registered occupancy, never on m_axis_tready.
  assign ready         = (level != CW'(DEPTH));
  assign m_axis_tvalid = (level != '0);
  assign m_axis_tdata  = mem[rd_ptr];

  assign wr_en = valid && ready;
  assign rd_en = m_axis_tvalid && m_axis_tready;

  // NOTE: storage is deliberately left out of reset so it can map onto plain RAM/LUT cells;
  // its contents are meaningless while level is 0.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // NOTE: all sequential state uses non-blocking assignment so every register samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + CW'(1);
        2'b01:   level <= level - CW'(1);
        default: level <= level;
      endcase
    end
  end

`ifdef AXIS_SOURCE_TLAST_EN
  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  logic [BW-1:0] beat_cnt;
  logic          at_last;

  assign at_last      = (beat_cnt == BW'(PKT_LEN - 1));
  assign m_axis_tlast = m_axis_tvalid && at_last;

  // Counts delivered beats only; a stalled or empty FIFO leaves the position in the packet untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt <= '0;
    end else if (rd_en) begin
      beat_cnt <= at_last ? '0 : beat_cnt + BW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_axis_source.sv
// Self-checking bench for axis_source: directed vector table, reset and streaming sequences,
// and randomized traffic against a queue-based reference model.
module tb_axis_source;

  localparam int W       = 32;
  localparam int DEPTH   = 4;
  localparam int PKT_LEN = 3;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          valid   = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          tready  = 1'b0;
  logic          ready;
  logic          tvalid;
  logic [W-1:0]  tdata;
  logic [CW-1:0] level;
`ifdef AXIS_SOURCE_TLAST_EN
  logic          tlast;
`endif

  int n_vec = 0;
  int n_err = 0;

  axis_source #(
    .AXIS_WIDTH (W),
    .DEPTH      (DEPTH),
    .PKT_LEN    (PKT_LEN)
  ) dut (
    .clk           (clk),
    .reset         (rst_n),
    .valid         (valid),
    .data_in       (data_in),
    .ready         (ready),
    .m_axis_tvalid (tvalid),
    .m_axis_tdata  (tdata),
    .m_axis_tready (tready),
`ifdef AXIS_SOURCE_TLAST_EN
    .m_axis_tlast  (tlast),
`endif
    .level         (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: FIFO contents as a queue, plus the number of beats delivered since reset.
  logic [W-1:0] q[$];
  logic [W-1:0] out_log[$];
  int           beats;

  task automatic model_reset();
    q.delete();
    beats = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, then advance the model.
  task automatic step(input logic v, input logic [W-1:0] d, input logic tr, output logic accepted);
    @(negedge clk);
    valid   = v;
    data_in = d;
    tready  = tr;
    #1;
    check("ready",  W'(ready),  W'(q.size() != DEPTH));
    check("tvalid", W'(tvalid), W'(q.size() != 0));
    check("level",  W'(level),  W'(q.size()));
    if (q.size() != 0) check("tdata", tdata, q[0]);
`ifdef AXIS_SOURCE_TLAST_EN
    check("tlast", W'(tlast), W'(q.size() != 0 && (beats % PKT_LEN) == PKT_LEN - 1));
`endif
    accepted = v && (q.size() != DEPTH);
    @(posedge clk);
    if (q.size() != 0 && tr) begin
      out_log.push_back(q.pop_front());
      beats++;
    end
    if (accepted) q.push_back(d);
  endtask

  typedef struct {
    logic          v;
    logic [W-1:0]  d;
    logic          tr;
    logic          e_ready;
    logic          e_tvalid;
    logic [W-1:0]  e_tdata;
    logic [CW-1:0] e_level;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic   acc;
    int     sent;
    int     cyc;
    logic   tr_pat[5];

    // Expected values describe the state seen before the edge on which the inputs are sampled.
    tbl[0]  = '{1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 1'b0, 32'h0,          3'd0};
    tbl[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'hA5A5_0001, 3'd1};
    tbl[2]  = '{1'b1, 32'h10,        1'b0, 1'b1, 1'b0, 32'h0,          3'd0};
    tbl[3]  = '{1'b1, 32'h11,        1'b0, 1'b1, 1'b1, 32'h10,         3'd1};
    tbl[4]  = '{1'b1, 32'h12,        1'b0, 1'b1, 1'b1, 32'h10,         3'd2};
    tbl[5]  = '{1'b1, 32'h13,        1'b0, 1'b1, 1'b1, 32'h10,         3'd3};
    tbl[6]  = '{1'b1, 32'h14,        1'b0, 1'b0, 1'b1, 32'h10,         3'd4};
    tbl[7]  = '{1'b1, 32'h14,        1'b0, 1'b0, 1'b1, 32'h10,         3'd4};
    tbl[8]  = '{1'b1, 32'h14,        1'b1, 1'b0, 1'b1, 32'h10,         3'd4};
    tbl[9]  = '{1'b1, 32'h14,        1'b1, 1'b1, 1'b1, 32'h11,         3'd3};
    tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h12,         3'd3};
    tbl[11] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h13,         3'd2};
    tbl[12] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h14,         3'd1};
    tbl[13] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,          3'd0};

    // Reset state, before any clock edge.
    #1;
    check("rst_ready",  W'(ready),  W'(1'b1));
    check("rst_tvalid", W'(tvalid), W'(1'b0));
    check("rst_level",  W'(level),  W'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      valid   = tbl[i].v;
      data_in = tbl[i].d;
      tready  = tbl[i].tr;
      #1;
      check($sformatf("vec%0d_ready", i),  W'(ready),  W'(tbl[i].e_ready));
      check($sformatf("vec%0d_tvalid", i), W'(tvalid), W'(tbl[i].e_tvalid));
      check($sformatf("vec%0d_level", i),  W'(level),  W'(tbl[i].e_level));
      if (tbl[i].e_tvalid) check($sformatf("vec%0d_tdata", i), tdata, tbl[i].e_tdata);
    end

    // Reset mid-transfer: buffered words vanish without a clock edge.
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b1, W'(32'hC0 + i), 1'b0, acc);
    @(negedge clk);
    valid  = 1'b1;
    tready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_tvalid", W'(tvalid), W'(1'b0));
    check("async_rst_ready",  W'(ready),  W'(1'b1));
    check("async_rst_level",  W'(level),  W'(0));
    model_reset();
    valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'hBEEF_0000, 1'b0, acc);
    step(1'b0, 32'h0, 1'b1, acc);
    step(1'b0, 32'h0, 1'b0, acc);

    // Streaming 0..19 with a repeating tready pattern; pointers wrap five times.
    tr_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    out_log.delete();
    sent = 0;
    cyc  = 0;
    while (sent < 20 && cyc < 200) begin
      step(1'b1, W'(sent), tr_pat[cyc % 5], acc);
      if (acc) sent++;
      cyc++;
    end
    while (q.size() != 0 && cyc < 300) begin
      step(1'b0, 32'h0, 1'b1, acc);
      cyc++;
    end
    check("stream_sent",  W'(sent),           W'(20));
    check("stream_count", W'(out_log.size()), W'(20));
    for (int k = 0; k < 20 && k < out_log.size(); k++) begin
      check($sformatf("stream_word%0d", k), out_log[k], W'(k));
    end

    // Randomized traffic in phases of varying producer and consumer pressure.
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 150; c++) begin
        logic v;
        logic tr;
        v  = ($urandom_range(0, 3) < ((ph == 1) ? 1 : 3));
        tr = ($urandom_range(0, 3) < ((ph == 2) ? 1 : 3));
        step(v, $urandom, tr, acc);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
